// File: rtl/div_iter_if.sv
// Handshake between the EX stage and the iterative divider.
interface div_iter_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start;
   logic                 signed_div;
   logic [WIDTH-1:0]     opdata1;
   logic [WIDTH-1:0]     opdata2;
   logic                 annul;
   logic [2*WIDTH-1:0]   result;
   logic                 ready;
   logic                 stallreq;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, stallreq
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, stallreq
   );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result delivered as {remainder, quotient}.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input logic      clk,
   input logic      rst,
   div_iter_if.slave bus
);
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned REM_W  = WIDTH + 1;
   localparam int unsigned WORK_W = 2 * WIDTH + 1;
   localparam int unsigned RES_W  = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORK_W-1:0]   work_q, work_d;
   logic [WIDTH-1:0]    divisor_q, divisor_d;
   logic                neg_quot_q, neg_quot_d;
   logic                neg_rem_q, neg_rem_d;
   logic [RES_W-1:0]    result_q, result_d;
   logic                ready_q, ready_d;

   logic                dividend_neg, divisor_neg;
   logic [WIDTH-1:0]    dividend_abs, divisor_abs;
   logic [WORK_W-1:0]   shifted, work_step;
   logic [REM_W-1:0]    trial;
   logic [WIDTH-1:0]    quot_raw, rem_raw, quot_fix, rem_fix;

   // Operand magnitudes and one restoring step
   always_comb begin
      dividend_neg = bus.signed_div & bus.opdata1[WIDTH-1];
      divisor_neg  = bus.signed_div & bus.opdata2[WIDTH-1];
      dividend_abs = dividend_neg ? (WIDTH'(0) - bus.opdata1) : bus.opdata1;
      divisor_abs  = divisor_neg  ? (WIDTH'(0) - bus.opdata2) : bus.opdata2;

      shifted   = work_q << 1;
      trial     = shifted[WORK_W-1:WIDTH] - {1'b0, divisor_q};
      work_step = trial[REM_W-1] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};

      quot_raw  = work_step[WIDTH-1:0];
      rem_raw   = WIDTH'(work_step[WORK_W-1:WIDTH]);
      quot_fix  = neg_quot_q ? (WIDTH'(0) - quot_raw) : quot_raw;
      rem_fix   = neg_rem_q  ? (WIDTH'(0) - rem_raw)  : rem_raw;
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;

      if (bus.annul) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.opdata2 == '0) begin
                     state_d = ZERO;
                  end else begin
                     state_d    = BUSY;
                     cnt_d      = '0;
                     work_d     = {REM_W'(0), dividend_abs};
                     divisor_d  = divisor_abs;
                     neg_quot_d = dividend_neg ^ divisor_neg;
                     neg_rem_d  = dividend_neg;
                  end
               end
            end
            ZERO: begin
               state_d  = DONE;
               result_d = '0;
            end
            BUSY: begin
               work_d = work_step;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d  = DONE;
                  result_d = {rem_fix, quot_fix};
               end
            end
            DONE: begin
               if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      ready_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result   = result_q;
   assign bus.ready    = ready_q;
   assign bus.stallreq = bus.start & ~ready_q & ~bus.annul;
endmodule
